// File: rtl/ram_arb_pkg.sv
// Shared types and default sizes for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int ARB_AW = 8;
    localparam int ARB_DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker. Purely combinational: on a tie the port that
// was not granted last time wins; a single requester always wins.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic  req0,
    input  logic  req1,
    input  port_t last_grant,
    output logic  valid,
    output port_t winner
);

    // Pick the winner from the request pair and the previous grant
    always_comb begin
        valid  = req0 | req1;
        winner = PORT0;
        if (req0 && req1) begin
            winner = (last_grant == PORT0) ? PORT1 : PORT0;
        end else if (req1) begin
            winner = PORT1;
        end else begin
            winner = PORT0;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between port 0
// (nanoprocessor) and port 1 (debug/loader). One access per three cycles:
// IDLE (grant and latch) -> ACCESS (RAM pins driven) -> RESP (ack pulse).
// Build option: ARB_WRITE_PROTECT_EN blocks port 0 writes below PROT_TOP and
// raises a sticky prot_err; without it prot_err never sets.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int             AW       = ARB_AW,
    parameter int             DW       = ARB_DW,
    parameter logic [AW-1:0]  PROT_TOP = AW'(8'h40)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_write,
    output logic [DW-1:0] ram_data_write,
    input  logic [DW-1:0] ram_data_read,
    output logic          busy,
    output logic          prot_err
);

`ifdef ARB_WRITE_PROTECT_EN
    localparam logic PROT_ON = 1'b1;
`else
    localparam logic PROT_ON = 1'b0;
`endif

    arb_state_t    state_q, state_d;
    port_t         last_grant_q, last_grant_d;
    port_t         winner_q, winner_d;
    logic          we_q, we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          ram_write_q, ram_write_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          prot_err_q, prot_err_d;

    logic          pick_valid_s;
    port_t         pick_winner_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;
    logic          prot_hit_s;
    logic [DW-1:0] rd_value_s;

    rr_pick2 u_pick (
        .req0       (p0_req),
        .req1       (p1_req),
        .last_grant (last_grant_q),
        .valid      (pick_valid_s),
        .winner     (pick_winner_s)
    );

    // Route the winning port's command fields towards the RAM registers
    always_comb begin
        sel_we_s    = p0_we;
        sel_addr_s  = p0_addr;
        sel_wdata_s = p0_wdata;
        if (pick_winner_s == PORT1) begin
            sel_we_s    = p1_we;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
        end else begin
            sel_we_s    = p0_we;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
        end
    end

    // A port 0 write into the low protected window; constant 0 when compiled out
    assign prot_hit_s = PROT_ON & (pick_winner_s == PORT0) & p0_we & (p0_addr < PROT_TOP);

    // Next-state and next-output logic of the IDLE/ACCESS/RESP sequence
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        we_d         = we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_write_d  = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        prot_err_d   = prot_err_q;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    winner_d    = pick_winner_s;
                    we_d        = sel_we_s;
                    ram_addr_d  = sel_addr_s;
                    ram_wdata_d = sel_wdata_s;
                    ram_write_d = sel_we_s & ~prot_hit_s;
                    prot_err_d  = prot_err_q | prot_hit_s;
                    state_d     = ACCESS;
                end else begin
                    state_d     = IDLE;
                end
            end
            ACCESS: begin
                // The ack is registered here so it is high during RESP
                ack0_d  = (winner_q == PORT0);
                ack1_d  = (winner_q == PORT1);
                state_d = RESP;
            end
            RESP: begin
                last_grant_d = winner_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= PORT1;
            winner_q     <= PORT0;
            we_q         <= 1'b0;
            ram_addr_q   <= {AW{1'b0}};
            ram_wdata_q  <= {DW{1'b0}};
            ram_write_q  <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            prot_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            we_q         <= we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_write_q  <= ram_write_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            prot_err_q   <= prot_err_d;
        end
    end

    // RAM read data only arrives in RESP (one-cycle RAM latency), so the
    // returned data is steered from ram_data_read rather than re-registered.
    assign rd_value_s     = we_q ? ram_wdata_q : ram_data_read;
    assign p0_rdata       = ack0_q ? rd_value_s : {DW{1'b0}};
    assign p1_rdata       = ack1_q ? rd_value_s : {DW{1'b0}};
    assign p0_ack         = ack0_q;
    assign p1_ack         = ack1_q;
    assign ram_addr       = ram_addr_q;
    assign ram_write      = ram_write_q;
    assign ram_data_write = ram_wdata_q;
    assign busy           = (state_q != IDLE);
    assign prot_err       = prot_err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbiter and RAM.
module tb_ram_arbiter;

`ifdef ARB_WRITE_PROTECT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif
    localparam logic [7:0] PROT_TOP = 8'h40;

    logic       clk = 1'b0;
    logic       reset;
    logic       p0_req, p0_we, p1_req, p1_we;
    logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic       p0_ack, p1_ack;
    logic [7:0] p0_rdata, p1_rdata;
    logic [7:0] ram_addr, ram_data_write;
    logic [7:0] ram_data_read;
    logic       ram_write, busy, prot_err;

    logic [7:0] ram_mem [256];
    logic [7:0] ref_mem [256];
    logic       preload_en = 1'b0;
    logic [7:0] preload_addr = 8'h00;
    logic [7:0] preload_data = 8'h00;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(8), .DW(8), .PROT_TOP(8'h40)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .ram_addr(ram_addr), .ram_write(ram_write), .ram_data_write(ram_data_write),
        .ram_data_read(ram_data_read), .busy(busy), .prot_err(prot_err)
    );

    // Single-port RAM with registered read data and a preload path
    always @(posedge clk) begin
        if (preload_en) ram_mem[preload_addr] <= preload_data;
        else if (ram_write) ram_mem[ram_addr] <= ram_data_write;
        ram_data_read <= ram_mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 8'h00; p0_wdata = 8'h00;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 8'h00; p1_wdata = 8'h00;
    endtask

    task automatic drive(input bit port, input bit we, input logic [7:0] addr, input logic [7:0] wdata);
        if (port) begin p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1; end
        else      begin p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1; end
    endtask

    // One complete transaction: drive, wait (bounded) for ack, drop req, one idle cycle
    task automatic xfer(input bit port, input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                        output logic [7:0] rdata, output int lat, output int wr_cycles,
                        output logic [7:0] wr_addr);
        rdata = 8'h00; lat = -1; wr_cycles = 0; wr_addr = 8'h00;
        drive(port, we, addr, wdata);
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            tick();
            if (ram_write === 1'b1) begin wr_cycles++; wr_addr = ram_addr; end
            if ((port ? p1_ack : p0_ack) === 1'b1) begin
                lat = c;
                rdata = port ? p1_rdata : p0_rdata;
            end
        end
        clear_reqs();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_reqs();
        preload_en = 1'b1;
        for (int a = 0; a < 256; a++) begin
            preload_addr = 8'(a);
            preload_data = (a == 16) ? 8'hA5 : (a == 5) ? 8'h11 : 8'($urandom_range(0, 255));
            ref_mem[a] = preload_data;
            tick();
        end
        preload_en = 1'b0;
        tick();
        vec_cnt++;
        if ({p0_ack, p1_ack, ram_write, busy, prot_err} !== 5'b0) begin
            err_cnt++;
            $display("FAIL reset_ctrl: got %b expected 00000", {p0_ack, p1_ack, ram_write, busy, prot_err});
        end
        vec_cnt++;
        if ({p0_rdata, p1_rdata, ram_addr, ram_data_write} !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset_data: got %h expected 00000000", {p0_rdata, p1_rdata, ram_addr, ram_data_write});
        end
        reset = 1'b0;
        tick();
        vec_cnt++;
        if ({busy, p0_ack, p1_ack} !== 3'b0) begin
            err_cnt++;
            $display("FAIL idle_no_req: got %b expected 000", {busy, p0_ack, p1_ack});
        end
    endtask

    task automatic test_single_read();
        int busy_n = 0;
        int lat = -1;
        bit p1_seen = 1'b0;
        logic [7:0] rd = 8'h00;
        drive(1'b0, 1'b0, 8'h10, 8'h00);
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (busy === 1'b1) busy_n++;
            if (p1_ack !== 1'b0) p1_seen = 1'b1;
            if (p0_ack === 1'b1 && lat < 0) begin lat = c; rd = p0_rdata; p0_req = 1'b0; end
        end
        vec_cnt++;
        if (lat !== 2) begin err_cnt++; $display("FAIL read_latency: got %0d expected 2", lat); end
        vec_cnt++;
        if (rd !== 8'hA5) begin err_cnt++; $display("FAIL read_data: got %h expected a5", rd); end
        vec_cnt++;
        if (p1_seen !== 1'b0) begin err_cnt++; $display("FAIL read_p1_ack: got %b expected 0", p1_seen); end
        vec_cnt++;
        if (busy_n !== 2) begin err_cnt++; $display("FAIL read_busy_cycles: got %0d expected 2", busy_n); end
        vec_cnt++;
        if (p0_rdata !== 8'h00) begin err_cnt++; $display("FAIL rdata_idle: got %h expected 00", p0_rdata); end
    endtask

    task automatic test_write_read();
        logic [7:0] rd, wa;
        int lat, wr;
        xfer(1'b1, 1'b1, 8'h80, 8'h3C, rd, lat, wr, wa);
        ref_mem[8'h80] = 8'h3C;
        vec_cnt++;
        if (wr !== 1 || wa !== 8'h80) begin
            err_cnt++; $display("FAIL write_pulse: got %0d cycles addr %h expected 1 cycle addr 80", wr, wa);
        end
        vec_cnt++;
        if (lat !== 2) begin err_cnt++; $display("FAIL write_ack: got %0d expected 2", lat); end
        xfer(1'b1, 1'b0, 8'h80, 8'h00, rd, lat, wr, wa);
        vec_cnt++;
        if (rd !== 8'h3C || lat !== 2) begin
            err_cnt++; $display("FAIL readback_p1: got %h lat %0d expected 3c lat 2", rd, lat);
        end
        vec_cnt++;
        if (wr !== 0) begin err_cnt++; $display("FAIL read_no_write: got %0d expected 0", wr); end
    endtask

    task automatic test_contention();
        int n0 = 0;
        int n1 = 0;
        bit e0, e1;
        clear_reqs();
        reset = 1'b1;
        drive(1'b0, 1'b0, 8'h10, 8'h00);
        drive(1'b1, 1'b0, 8'h80, 8'h00);
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            e0 = (c % 3 == 2) && ((c / 3) % 2 == 0);
            e1 = (c % 3 == 2) && ((c / 3) % 2 == 1);
            if (p0_ack === 1'b1) n0++;
            if (p1_ack === 1'b1) n1++;
            vec_cnt++;
            if ({p0_ack, p1_ack} !== {e0, e1}) begin
                err_cnt++; $display("FAIL contention_ack c%0d: got %b expected %b", c, {p0_ack, p1_ack}, {e0, e1});
            end
            vec_cnt++;
            if (p0_rdata !== (e0 ? 8'hA5 : 8'h00) || p1_rdata !== (e1 ? 8'h3C : 8'h00)) begin
                err_cnt++; $display("FAIL contention_rdata c%0d: got %h/%h", c, p0_rdata, p1_rdata);
            end
        end
        vec_cnt++;
        if (n0 !== 2 || n1 !== 2) begin
            err_cnt++; $display("FAIL contention_fair: got %0d/%0d expected 2/2", n0, n1);
        end
        clear_reqs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        bit ack_seen = 1'b0;
        drive(1'b0, 1'b1, 8'h20, 8'h55);
        tick();
        vec_cnt++;
        if (ram_write !== 1'b1 || ram_addr !== 8'h20 || busy !== 1'b1) begin
            err_cnt++; $display("FAIL midrst_access: got we %b addr %h busy %b expected 1 20 1", ram_write, ram_addr, busy);
        end
        reset = 1'b1;
        tick();
        vec_cnt++;
        if ({p0_ack, p1_ack, ram_write, busy, prot_err} !== 5'b0 ||
            {p0_rdata, p1_rdata, ram_addr, ram_data_write} !== 32'h0) begin
            err_cnt++; $display("FAIL midrst_outputs: got %b %h expected all zero",
                                {p0_ack, p1_ack, ram_write, busy, prot_err},
                                {p0_rdata, p1_rdata, ram_addr, ram_data_write});
        end
        reset = 1'b0;
        clear_reqs();
        ref_mem[8'h20] = 8'h55;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (p0_ack !== 1'b0 || busy !== 1'b0) ack_seen = 1'b1;
        end
        vec_cnt++;
        if (ack_seen !== 1'b0) begin err_cnt++; $display("FAIL midrst_no_ack: got 1 expected 0"); end
    endtask

    task automatic test_back_to_back();
        bit ea, eb;
        logic [7:0] er;
        drive(1'b0, 1'b0, 8'h10, 8'h00);
        for (int c = 1; c <= 8; c++) begin
            tick();
            ea = (c == 2) || (c == 6);
            eb = (c == 1) || (c == 2) || (c == 5) || (c == 6);
            er = (c == 2) ? 8'hA5 : (c == 6) ? 8'h3C : 8'h00;
            vec_cnt++;
            if (p0_ack !== ea || busy !== eb || p0_rdata !== er) begin
                err_cnt++;
                $display("FAIL b2b c%0d: got ack %b busy %b rdata %h expected %b %b %h",
                         c, p0_ack, busy, p0_rdata, ea, eb, er);
            end
            if (c == 3) p0_req = 1'b0;
            if (c == 4) drive(1'b0, 1'b0, 8'h80, 8'h00);
            if (c == 6) p0_req = 1'b0;
        end
        clear_reqs();
    endtask

    task automatic test_protect();
        logic [7:0] rd, wa;
        int lat, wr;
        xfer(1'b0, 1'b1, 8'h05, 8'h77, rd, lat, wr, wa);
        if (!PROT_ON) ref_mem[8'h05] = 8'h77;
        vec_cnt++;
        if (lat !== 2 || wr !== (PROT_ON ? 0 : 1)) begin
            err_cnt++; $display("FAIL prot_p0_write: got lat %0d writes %0d expected 2 %0d", lat, wr, PROT_ON ? 0 : 1);
        end
        vec_cnt++;
        if (prot_err !== PROT_ON) begin err_cnt++; $display("FAIL prot_err_set: got %b expected %b", prot_err, PROT_ON); end
        xfer(1'b0, 1'b0, 8'h05, 8'h00, rd, lat, wr, wa);
        vec_cnt++;
        if (rd !== (PROT_ON ? 8'h11 : 8'h77)) begin
            err_cnt++; $display("FAIL prot_readback: got %h expected %h", rd, PROT_ON ? 8'h11 : 8'h77);
        end
        xfer(1'b0, 1'b1, 8'h40, 8'h9A, rd, lat, wr, wa);
        ref_mem[8'h40] = 8'h9A;
        vec_cnt++;
        if (wr !== 1 || wa !== 8'h40) begin err_cnt++; $display("FAIL prot_boundary: got %0d addr %h expected 1 40", wr, wa); end
        xfer(1'b1, 1'b1, 8'h05, 8'h77, rd, lat, wr, wa);
        ref_mem[8'h05] = 8'h77;
        vec_cnt++;
        if (wr !== 1) begin err_cnt++; $display("FAIL prot_p1_write: got %0d expected 1", wr); end
        xfer(1'b1, 1'b0, 8'h05, 8'h00, rd, lat, wr, wa);
        vec_cnt++;
        if (rd !== 8'h77 || prot_err !== PROT_ON) begin
            err_cnt++; $display("FAIL prot_p1_readback: got %h err %b expected 77 %b", rd, prot_err, PROT_ON);
        end
    endtask

    task automatic test_random();
        int g = -100;
        bit mp = 1'b0, m_last = 1'b1, m_wr = 1'b0, m_prot = 1'b0;
        logic [7:0] m_rd = 8'h00, m_addr = 8'h00, m_wd = 8'h00;
        bit e0, e1, eb, ew, w, prot;
        clear_reqs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (k > 0) tick();
            e0 = (k == g + 2) && !mp;
            e1 = (k == g + 2) && mp;
            eb = (k == g + 1) || (k == g + 2);
            ew = (k == g + 1) && m_wr;
            vec_cnt++;
            if ({p0_ack, p1_ack, busy, ram_write, prot_err} !== {e0, e1, eb, ew, m_prot}) begin
                err_cnt++; $display("FAIL rand_ctrl k%0d: got %b expected %b", k,
                                    {p0_ack, p1_ack, busy, ram_write, prot_err}, {e0, e1, eb, ew, m_prot});
            end
            vec_cnt++;
            if (p0_rdata !== (e0 ? m_rd : 8'h00) || p1_rdata !== (e1 ? m_rd : 8'h00)) begin
                err_cnt++; $display("FAIL rand_rdata k%0d: got %h/%h expected %h", k, p0_rdata, p1_rdata, m_rd);
            end
            if (k == g + 1) begin
                vec_cnt++;
                if (ram_addr !== m_addr || (m_wr && ram_data_write !== m_wd)) begin
                    err_cnt++; $display("FAIL rand_ram_bus k%0d: got %h/%h expected %h/%h", k,
                                        ram_addr, ram_data_write, m_addr, m_wd);
                end
            end
            if (e0) p0_req = 1'b0;
            else if (!p0_req && $urandom_range(0, 2) == 0)
                drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            if (e1) p1_req = 1'b0;
            else if (!p1_req && $urandom_range(0, 2) == 0)
                drive(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            if (k >= g + 3 && (p0_req || p1_req)) begin
                mp     = (p0_req && p1_req) ? !m_last : p1_req;
                w      = mp ? p1_we : p0_we;
                m_addr = mp ? p1_addr : p0_addr;
                m_wd   = mp ? p1_wdata : p0_wdata;
                prot   = PROT_ON && !mp && w && (m_addr < PROT_TOP);
                m_wr   = w && !prot;
                if (m_wr) ref_mem[m_addr] = m_wd;
                m_rd   = w ? m_wd : ref_mem[m_addr];
                if (prot) m_prot = 1'b1;
                m_last = mp;
                g      = k;
            end
        end
        clear_reqs();
        tick();
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_reset_mid_access();
        test_back_to_back();
        test_protect();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
